// File: rtl/fifo_bank4.sv
// fifo_bank4: four independent synchronous FIFO lanes feeding one arbiter.
// The arbiter pops one lane at a time through a one-hot pop vector and receives
// a single registered output word plus per-lane status and sticky error flags.
//
// Ports:
//   clk          rising-edge clock
//   reset        asynchronous active-low reset
//   data_in      4 lanes of DATA_W, lane i at [i*DATA_W +: DATA_W]
//   push         per-lane write strobe
//   pop          one-hot read request (zero = idle, >1 bit = illegal)
//   fifo_out     registered word popped on the previous edge
//   valid_out    fifo_out was updated on the last edge
//   empty        per-lane occupancy == 0
//   almost_full  per-lane occupancy >= AF_THRESH
//   full         per-lane occupancy == DEPTH
//   error        sticky per-lane error flags (illegal pop, empty pop, overflow)
module fifo_bank4 #(
  parameter int unsigned DATA_W    = 12,
  parameter int unsigned DEPTH     = 8,
  parameter int unsigned AF_THRESH = 6
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [4*DATA_W-1:0]   data_in,
  input  logic [3:0]            push,
  input  logic [3:0]            pop,
  output logic [DATA_W-1:0]     fifo_out,
  output logic                  valid_out,
  output logic [3:0]            empty,
  output logic [3:0]            almost_full,
  output logic [3:0]            full,
  output logic [3:0]            error
);

  localparam int unsigned LANES = 4;
  localparam int unsigned AW    = $clog2(DEPTH);
  localparam int unsigned CW    = AW + 1;

  logic [DATA_W-1:0] mem [LANES][DEPTH];
  logic [AW-1:0]     wptr [LANES];
  logic [AW-1:0]     rptr [LANES];
  logic [CW-1:0]     count [LANES];
  logic [CW-1:0]     count_next [LANES];

  logic              pop_onehot;
  logic              pop_multi;
  logic [3:0]        pop_acc;
  logic [3:0]        push_acc;
  logic [3:0]        err_set;
  logic [DATA_W-1:0] pop_word;

  // Pop qualification: only a one-hot vector can pop anything.
  always_comb begin
    pop_onehot = ($countones(pop) == 1);
    pop_multi  = ($countones(pop) > 1);
  end

  // Per-lane accept decisions and error sources; empty/full are the registered
  // flags, so an empty-lane pop is not rescued by a same-cycle push.
  always_comb begin
    pop_acc  = '0;
    push_acc = '0;
    err_set  = '0;
    for (int i = 0; i < LANES; i++) begin
      pop_acc[i]  = pop_onehot && pop[i] && !empty[i];
      push_acc[i] = push[i] && (!full[i] || pop_acc[i]);
      err_set[i]  = (pop_multi && pop[i])
                  | (pop_onehot && pop[i] && empty[i])
                  | (push[i] && full[i] && !pop_acc[i]);
    end
  end

  // Occupancy after this edge; flags are derived from it so they are exact.
  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      count_next[i] = count[i] + CW'(push_acc[i]) - CW'(pop_acc[i]);
    end
  end

  // Read mux: at most one pop_acc bit is ever set.
  always_comb begin
    pop_word = '0;
    for (int i = 0; i < LANES; i++) begin
      if (pop_acc[i]) pop_word = mem[i][rptr[i]];
    end
  end

  // Storage array, intentionally not reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < LANES; i++) begin
      if (push_acc[i]) mem[i][wptr[i]] <= data_in[i*DATA_W +: DATA_W];
    end
  end

  // Pointers, counts and registered flags.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < LANES; i++) begin
        wptr[i]  <= '0;
        rptr[i]  <= '0;
        count[i] <= '0;
      end
      empty       <= 4'hF;
      full        <= '0;
      almost_full <= '0;
      error       <= '0;
    end else begin
      for (int i = 0; i < LANES; i++) begin
        if (push_acc[i]) wptr[i] <= wptr[i] + AW'(1);
        if (pop_acc[i])  rptr[i] <= rptr[i] + AW'(1);
        count[i]       <= count_next[i];
        empty[i]       <= (count_next[i] == '0);
        full[i]        <= (count_next[i] == CW'(DEPTH));
        almost_full[i] <= (count_next[i] >= CW'(AF_THRESH));
      end
      error <= error | err_set;
    end
  end

  // Output register: holds the last popped word when nothing is accepted.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fifo_out  <= '0;
      valid_out <= 1'b0;
    end else begin
      valid_out <= |pop_acc;
      if (|pop_acc) fifo_out <= pop_word;
    end
  end

endmodule

// File: tb/tb_fifo_bank4.sv
// Testbench for fifo_bank4: directed scenarios plus randomized traffic, all
// checked every cycle against a queue-based model of the four lanes.
module tb_fifo_bank4;

  localparam int unsigned DATA_W = 12;
  localparam int unsigned DEPTH  = 8;
  localparam int unsigned AF     = 6;

  logic                clk = 1'b0;
  logic                reset;
  logic [4*DATA_W-1:0] data_in;
  logic [3:0]          push;
  logic [3:0]          pop;
  logic [DATA_W-1:0]   fifo_out;
  logic                valid_out;
  logic [3:0]          empty;
  logic [3:0]          almost_full;
  logic [3:0]          full;
  logic [3:0]          error;

  fifo_bank4 #(.DATA_W(DATA_W), .DEPTH(DEPTH), .AF_THRESH(AF)) dut (
    .clk(clk), .reset(reset), .data_in(data_in), .push(push), .pop(pop),
    .fifo_out(fifo_out), .valid_out(valid_out), .empty(empty),
    .almost_full(almost_full), .full(full), .error(error)
  );

  always #5 clk = ~clk;

  // Reference model: one queue per lane plus the visible output state.
  logic [DATA_W-1:0] q [4][$];
  logic [3:0]        m_err;
  logic [DATA_W-1:0] m_out;
  logic              m_valid;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Compare every DUT output against the model.
  task automatic check_all(input string tag);
    logic [3:0] e_empty, e_full, e_af;
    for (int i = 0; i < 4; i++) begin
      e_empty[i] = (q[i].size() == 0);
      e_full[i]  = (q[i].size() == DEPTH);
      e_af[i]    = (q[i].size() >= AF);
    end
    chk({tag, " empty"}, 64'(empty), 64'(e_empty));
    chk({tag, " full"}, 64'(full), 64'(e_full));
    chk({tag, " almost_full"}, 64'(almost_full), 64'(e_af));
    chk({tag, " error"}, 64'(error), 64'(m_err));
    chk({tag, " valid_out"}, 64'(valid_out), 64'(m_valid));
    chk({tag, " fifo_out"}, 64'(fifo_out), 64'(m_out));
  endtask

  function automatic logic [4*DATA_W-1:0] rand_data();
    logic [4*DATA_W-1:0] d;
    for (int i = 0; i < 4; i++) d[i*DATA_W +: DATA_W] = DATA_W'($urandom);
    return d;
  endfunction

  function automatic logic [4*DATA_W-1:0] lane_data(input int lane, input logic [DATA_W-1:0] v);
    logic [4*DATA_W-1:0] d;
    d = rand_data();
    d[lane*DATA_W +: DATA_W] = v;
    return d;
  endfunction

  // Apply one cycle of stimulus, advance the model, then check after the edge.
  task automatic step(input logic [3:0] pu, input logic [3:0] po, input logic [4*DATA_W-1:0] d);
    int ones;
    push = pu; pop = po; data_in = d;
    ones = $countones(po);
    m_valid = 1'b0;
    if (ones > 1) begin
      m_err = m_err | po;
    end else if (ones == 1) begin
      for (int i = 0; i < 4; i++) begin
        if (po[i]) begin
          if (q[i].size() > 0) begin
            m_out   = q[i].pop_front();
            m_valid = 1'b1;
          end else begin
            m_err[i] = 1'b1;
          end
        end
      end
    end
    for (int i = 0; i < 4; i++) begin
      if (pu[i]) begin
        if (q[i].size() < DEPTH) q[i].push_back(d[i*DATA_W +: DATA_W]);
        else m_err[i] = 1'b1;
      end
    end
    @(posedge clk); #1;
    check_all("cyc");
  endtask

  task automatic idle();
    step(4'b0, 4'b0, rand_data());
  endtask

  // Async reset asserted between edges; outputs must clear without a clock.
  task automatic do_reset();
    push = '0; pop = '0;
    #2 reset = 1'b0;
    #1;
    chk("rst empty", 64'(empty), 64'hF);
    chk("rst full", 64'(full), 64'h0);
    chk("rst almost_full", 64'(almost_full), 64'h0);
    chk("rst fifo_out", 64'(fifo_out), 64'h0);
    chk("rst valid_out", 64'(valid_out), 64'h0);
    chk("rst error", 64'(error), 64'h0);
    for (int i = 0; i < 4; i++) q[i].delete();
    m_err = '0; m_out = '0; m_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
  endtask

  task automatic random_phase(input int n, input bit heavy);
    logic [3:0] pu, po;
    int r;
    for (int k = 0; k < n; k++) begin
      pu = heavy ? 4'($urandom) : 4'($urandom & $urandom);
      r  = $urandom_range(0, 11);
      if (r == 0)      po = '0;
      else if (r == 1) po = 4'($urandom);
      else             po = 4'(1 << $urandom_range(0, 3));
      step(pu, po, rand_data());
    end
  endtask

  initial begin
    reset = 1'b0; push = '0; pop = '0; data_in = '0;
    m_err = '0; m_out = '0; m_valid = 1'b0;

    // Reset held with clocks running.
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      chk("hold empty", 64'(empty), 64'hF);
      chk("hold fifo_out", 64'(fifo_out), 64'h0);
      chk("hold valid_out", 64'(valid_out), 64'h0);
      chk("hold error", 64'(error), 64'h0);
    end
    reset = 1'b1;
    idle();

    // Lane 0 ordering.
    step(4'b0001, 4'b0, lane_data(0, 12'h296));
    chk("l0 not empty", 64'(empty[0]), 64'h0);
    step(4'b0001, 4'b0, lane_data(0, 12'hAF0));
    step(4'b0001, 4'b0, lane_data(0, 12'h750));
    step(4'b0, 4'b0001, rand_data());
    chk("l0 pop1", 64'(fifo_out), 64'h296);
    step(4'b0, 4'b0001, rand_data());
    chk("l0 pop2", 64'(fifo_out), 64'hAF0);
    step(4'b0, 4'b0001, rand_data());
    chk("l0 pop3", 64'(fifo_out), 64'h750);
    chk("l0 pop3 valid", 64'(valid_out), 64'h1);
    chk("l0 empty", 64'(empty[0]), 64'h1);
    idle();
    chk("l0 idle valid", 64'(valid_out), 64'h0);
    chk("l0 idle hold", 64'(fifo_out), 64'h750);

    // Lane 2 fill: almost_full at 6, full at 8, 9th push dropped.
    for (int k = 1; k <= 9; k++) begin
      step(4'b0100, 4'b0, lane_data(2, 12'(12'h200 + k)));
      if (k == 5) chk("l2 af at 5", 64'(almost_full[2]), 64'h0);
      if (k == 6) chk("l2 af at 6", 64'(almost_full[2]), 64'h1);
      if (k == 7) chk("l2 full at 7", 64'(full[2]), 64'h0);
      if (k == 8) chk("l2 full at 8", 64'(full[2]), 64'h1);
      if (k == 8) chk("l2 err at 8", 64'(error[2]), 64'h0);
    end
    chk("l2 overflow err", 64'(error[2]), 64'h1);
    chk("l2 still full", 64'(full[2]), 64'h1);
    for (int k = 1; k <= 8; k++) begin
      step(4'b0, 4'b0100, rand_data());
      chk("l2 drain", 64'(fifo_out), 64'(12'h200 + k));
    end
    chk("l2 drained", 64'(empty[2]), 64'h1);

    // Lane 1 full with simultaneous push and pop.
    for (int k = 0; k < 8; k++) step(4'b0010, 4'b0, lane_data(1, 12'(12'h100 + k)));
    step(4'b0010, 4'b0010, lane_data(1, 12'h1FF));
    chk("l1 pp full", 64'(full[1]), 64'h1);
    chk("l1 pp oldest", 64'(fifo_out), 64'h100);
    chk("l1 pp no err", 64'(error[1]), 64'h0);
    for (int k = 0; k < 8; k++) step(4'b0, 4'b0010, rand_data());
    chk("l1 last word", 64'(fifo_out), 64'h1FF);

    // Illegal multi-bit pop, from a clean reset.
    do_reset();
    step(4'b0101, 4'b0, rand_data());
    step(4'b0, 4'b0101, rand_data());
    chk("illegal err", 64'(error), 64'h5);
    chk("illegal valid", 64'(valid_out), 64'h0);
    chk("illegal l0 kept", 64'(empty[0]), 64'h0);

    // Empty-lane pop with same-cycle push on lane 3.
    step(4'b1000, 4'b1000, lane_data(3, 12'h3C5));
    chk("l3 err", 64'(error), 64'hD);
    chk("l3 valid", 64'(valid_out), 64'h0);
    step(4'b0, 4'b1000, rand_data());
    chk("l3 next pop", 64'(fifo_out), 64'h3C5);
    chk("l3 next valid", 64'(valid_out), 64'h1);

    // Reset mid-traffic; stale contents must never reappear.
    do_reset();
    random_phase(40, 1'b1);
    do_reset();
    step(4'b0, 4'b0001, rand_data());
    chk("post rst pop valid", 64'(valid_out), 64'h0);
    chk("post rst pop err", 64'(error), 64'h1);
    for (int ln = 1; ln < 4; ln++) step(4'b0, 4'(1 << ln), rand_data());

    // Randomized traffic.
    do_reset();
    random_phase(600, 1'b1);
    do_reset();
    random_phase(800, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Hard time limit so the run always terminates.
  initial begin
    #200000;
    $display("FAIL timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/fifo_bank4.md
# fifo_bank4

Four-lane input buffer bank that sits directly upstream of the round-robin arbiter. Each lane is an independent synchronous FIFO written by its own source; the arbiter drains the bank one word at a time via a one-hot `pop` vector and sees a single registered `fifo_out` plus per-lane `empty` / `almost_full` status. The block provides the storage, flags and error detection the arbiter relies on for its scheduling and backpressure decisions.

## Interface
- `DATA_W`, 12: word width. Bits [DATA_W-1:DATA_W-2] carry the destination lane; the bank passes them through unchanged.
- `DEPTH`, 8: entries per lane; power of two, at least 4.
- `AF_THRESH`, 6: `almost_full[i]` is 1 when the occupancy of lane i is at least AF_THRESH; range 1..DEPTH-1.

- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-low; `reset`=0 clears all state.
- `data_in`  in  4*DATA_W  lane i data at [i*DATA_W +: DATA_W].
- `push`  in  4  per-lane write strobe.
- `pop`  in  4  one-hot read request from the arbiter.
- `fifo_out`  out  DATA_W  registered word popped on the previous edge.
- `valid_out`  out  1  `fifo_out` updated on the last edge.
- `empty`  out  4  per-lane occupancy is 0.
- `almost_full`  out  4  per-lane occupancy ≥ AF_THRESH.
- `full`  out  4  per-lane occupancy is DEPTH.
- `error`  out  4  sticky per-lane error flags; cleared only by reset.

## Operation
- Per lane: write pointer, read pointer (log2(DEPTH) bits, natural wrap), occupancy counter (log2(DEPTH)+1 bits), and a DEPTH×DATA_W memory. The memory is not reset.
- Push accept, lane i: `push[i]` && (!`full[i]` || pop accepted on lane i in the same cycle). On accept, write `data_in` lane i at wptr and increment wptr.
- Pop qualify: `pop` must be one-hot or zero. If `pop` has 2 or more bits set, no pop happens and `error[i]` is set for every i with `pop[i]`=1.
- Pop accept, lane i: `pop` one-hot at bit i and !`empty[i]`. On accept, `fifo_out` ← mem[rptr], rptr increments, and `valid_out`=1.
- Pop on empty lane i: ignored; `error[i]` is set; `fifo_out` holds; `valid_out`=0. A same-cycle push into the empty lane does not satisfy that pop.
- Overflow: `push[i]` while full without a same-cycle accepted pop on lane i. The word is dropped and `error[i]` is set.
- Occupancy: count_next = count + push_acc − pop_acc. A simultaneous push and pop leaves the count unchanged.
- Flags are registered and computed from count_next, so they are exact on the same edge that changes the count.
- When no pop is accepted, `fifo_out` holds its last value and `valid_out`=0.

## Timing
- Reset values (async, `reset`=0):
  - all pointers and counts 0
  - `empty`=4'b1111, `full`=0, `almost_full`=0
  - `fifo_out`=0, `valid_out`=0, `error`=0
- Latency:
  - Pop: accepted at edge N; data and `valid_out` are visible after edge N and held for one cycle.
  - Push: written at edge N; `empty` deasserts after edge N; the word is poppable in cycle N+1.
- The arbiter may assert `pop` back-to-back on the same lane every cycle. Throughput is one word per cycle per bank.
- No combinational path from any input to any output.
- Reset assertion mid-operation discards all contents immediately. Outputs return to reset values without waiting for a clock edge.
- After release, the first edge with `reset`=1 may accept push/pop.

## Test plan
- Reset check: hold `reset`=0 with clocks toggling -> `empty`=4'hF, `fifo_out`=0, `valid_out`=0, `error`=0.
- Lane 0 order: push 12'h296, 12'hAF0, 12'h750 on lane 0, then pop lane 0 three cycles running -> `fifo_out` is 296, AF0, 750 on consecutive cycles with `valid_out`=1; `empty[0]`=1 after the third pop.
- Fill lane 2 to 6 words -> `almost_full[2]` rises on the edge of the 6th push. Fill to 8 -> `full[2]`=1. A 9th push is dropped and sets `error[2]`=1; occupancy stays 8.
- Full lane 1 with simultaneous push and pop -> both accepted; `full[1]` stays 1; the popped word is the oldest.
- Illegal pop = 4'b0101 -> no pop occurs; `error` = 4'b0101; `valid_out`=0.
- Pop lane 3 while empty with a simultaneous push on lane 3 -> `error[3]`=1 and `valid_out`=0; the pushed word pops correctly next cycle.
- Reset mid-traffic: assert `reset` with lanes partially full -> all flags return to reset values immediately, and old data is never popped afterwards.
